// File: rtl/io_unlock_ctrl.sv
// rtl/io_unlock_ctrl.sv - Z80 I/O-port magic-sequence unlock controller driving NCHAN enable flags.
// Optional feature macro: IO_UNLOCK_TIMEOUT_EN (ARMED state expires after TIMEOUT clocks).
module io_unlock_ctrl #(
    parameter logic [15:0]          IOADDR      = 16'h007F,
    parameter int                   FULL_DECODE = 0,
    parameter int                   SEQ_LEN     = 8,
    parameter logic [SEQ_LEN*8-1:0] SEQ         = "ENABLEWR",
    parameter int                   NCHAN       = 4,
    parameter int                   TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      a,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             dout_oe,
    output logic [NCHAN-1:0] enable,
    output logic             armed
);

    typedef enum logic {S_HUNT, S_ARMED} state_t;

    state_t           r_state, w_next_state;
    logic [3:0]       r_index, w_next_index;
    logic [NCHAN-1:0] r_enable, w_next_enable;
    logic [7:0]       r_cmd_q;
    logic             r_in_write;
    logic             w_match, w_hit, w_commit;
    logic [7:0]       w_seq_byte, w_seq_first;
`ifdef IO_UNLOCK_TIMEOUT_EN
    logic [23:0]      r_timer, w_next_timer;
`endif

    always_comb begin
        w_match     = (FULL_DECODE != 0) ? (a == IOADDR) : (a[7:0] == IOADDR[7:0]);
        w_hit       = !iorq_n && w_match;
        // The strobe is considered released as soon as any of IORQ, WR or the address drops away.
        w_commit    = r_in_write && (iorq_n || wr_n || !w_match);
        w_seq_byte  = 8'(SEQ >> ((SEQ_LEN - 1 - int'(r_index)) * 8));
        w_seq_first = SEQ[SEQ_LEN*8-1 -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_write <= 1'b0;
            r_cmd_q    <= 8'h00;
        end else if (!r_in_write && w_hit && !wr_n) begin
            r_in_write <= 1'b1;
            r_cmd_q    <= din;
        end else if (w_commit) begin
            r_in_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HUNT;
            r_index  <= 4'd0;
            r_enable <= '0;
`ifdef IO_UNLOCK_TIMEOUT_EN
            r_timer  <= 24'd0;
`endif
        end else begin
            r_state  <= w_next_state;
            r_index  <= w_next_index;
            r_enable <= w_next_enable;
`ifdef IO_UNLOCK_TIMEOUT_EN
            r_timer  <= w_next_timer;
`endif
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_index  = r_index;
        w_next_enable = r_enable;
`ifdef IO_UNLOCK_TIMEOUT_EN
        w_next_timer  = r_timer;
        if (r_state == S_ARMED && r_timer != 24'd0) begin
            w_next_timer = r_timer - 24'd1;
        end
`endif
        case (r_state)
            S_HUNT: begin
                if (w_commit) begin
                    if (r_cmd_q == w_seq_byte) begin
                        if (r_index == 4'(SEQ_LEN - 1)) begin
                            w_next_state = S_ARMED;
                            w_next_index = 4'd0;
`ifdef IO_UNLOCK_TIMEOUT_EN
                            w_next_timer = 24'(TIMEOUT);
`endif
                        end else begin
                            w_next_index = r_index + 4'd1;
                        end
                    end else begin
                        // A wrong byte that is itself the first sequence byte restarts the match.
                        w_next_index = (r_cmd_q == w_seq_first) ? 4'd1 : 4'd0;
                    end
                end
            end
            S_ARMED: begin
                if (w_commit) begin
                    if (r_cmd_q[7]) begin
                        w_next_enable = r_enable | r_cmd_q[NCHAN-1:0];
                    end else begin
                        w_next_enable = r_enable & ~r_cmd_q[NCHAN-1:0];
                    end
                    w_next_state = S_HUNT;
                    w_next_index = 4'd0;
                end
`ifdef IO_UNLOCK_TIMEOUT_EN
                else if (r_timer == 24'd0) begin
                    w_next_state = S_HUNT;
                    w_next_index = 4'd0;
                end
`endif
            end
            default: begin
                w_next_state = S_HUNT;
                w_next_index = 4'd0;
            end
        endcase
    end

    always_comb begin
        armed            = (r_state == S_ARMED);
        enable           = r_enable;
        dout_oe          = w_hit && !rd_n;
        dout             = 8'h00;
        dout[7]          = armed;
        dout[NCHAN-1:0]  = r_enable;
    end

endmodule

// File: tb/tb_io_unlock_ctrl.sv
// tb/tb_io_unlock_ctrl.sv - Directed bench for io_unlock_ctrl with a byte-level reference model.
module tb_io_unlock_ctrl;

    localparam logic [15:0] PORT = 16'h007F;
`ifdef IO_UNLOCK_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic        iorq_n, rd_n, wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [3:0]  enable;
    logic        armed;

    always #5 clk = ~clk;

    io_unlock_ctrl #(
        .IOADDR(PORT), .FULL_DECODE(1), .SEQ_LEN(8), .SEQ("ENABLEWR"),
        .NCHAN(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .din(din), .dout(dout), .dout_oe(dout_oe), .enable(enable), .armed(armed)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         run_chk = 1'b0;
    bit         m_armed = 1'b0;
    int         m_idx   = 0;
    logic [3:0] m_en    = 4'h0;
    int         arm_cyc = 0;
    bit         pend    = 1'b0;
    int         pend_cyc = 0;
    logic [7:0] pend_byte = 8'h00;

    function automatic logic [7:0] seq_at(int i);
        logic [63:0] s;
        s = "ENABLEWR";
        return s[(7 - i) * 8 +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_commit(input logic [7:0] b);
        if (m_armed) begin
            if (b[7]) m_en = m_en | b[3:0];
            else      m_en = m_en & ~b[3:0];
            m_armed = 1'b0;
            m_idx   = 0;
        end else if (b == seq_at(m_idx)) begin
            if (m_idx == 7) begin
                m_armed = 1'b1;
                m_idx   = 0;
                arm_cyc = cyc;
            end else begin
                m_idx++;
            end
        end else begin
            m_idx = (b == seq_at(0)) ? 1 : 0;
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_idx   = 0;
        m_en    = 4'h0;
        pend    = 1'b0;
    endtask

    // Model advances one edge after a write strobe is released, or on timer expiry.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (rst_n) begin
            if (pend && cyc == pend_cyc + 1) begin
                pend = 1'b0;
                model_commit(pend_byte);
            end
`ifdef IO_UNLOCK_TIMEOUT_EN
            else if (m_armed && (cyc - arm_cyc) > TMO) begin
                m_armed = 1'b0;
                m_idx   = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("armed",   32'(armed),   32'(m_armed));
            chk("enable",  32'(enable),  32'(m_en));
            chk("dout",    32'(dout),    32'({m_armed, 3'b000, m_en}));
            chk("dout_oe", 32'(dout_oe), 32'(!iorq_n && a == PORT && !rd_n));
        end
    end

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input bit with_rd);
        @(posedge clk); #1;
        a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0; rd_n = !with_rd;
        @(posedge clk);
        @(posedge clk); #1;
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        if (addr == PORT) begin
            pend = 1'b1; pend_cyc = cyc; pend_byte = data;
        end
        @(posedge clk); #3;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) io_write(PORT, s[i], 1'b0);
    endtask

    task automatic io_read(input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        a = PORT; iorq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        chk(name, 32'(dout), 32'(exp));
        chk({name, "_oe"}, 32'(dout_oe), 32'd1);
        @(posedge clk); #1;
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; din = 8'h00;
        repeat (2) @(posedge clk);
        #1 run_chk = 1'b1;
        io_read(8'h00, "rst_read");
        chk("rst_enable", 32'(enable), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        write_str("ENABLEWR");
        chk("t2_armed", 32'(armed), 32'd1);
        io_write(PORT, 8'h85, 1'b0);
        chk("t2_enable", 32'(enable), 32'h5);
        chk("t2_model", 32'(m_en), 32'h5);
        io_read(8'h05, "t2_read");

        write_str("ENAE");
        chk("t3_partial", 32'(armed), 32'd0);
        write_str("ENABLEWR");
        chk("t3_armed", 32'(armed), 32'd1);
        io_write(PORT, 8'h01, 1'b0);
        io_read(8'h04, "t3_read");

        write_str("EEN");
        chk("t4_partial", 32'(armed), 32'd0);
        write_str("ABLEWR");
        chk("t4_armed", 32'(armed), 32'd1);
        io_write(PORT, 8'h82, 1'b0);
        io_read(8'h06, "t4_read");

        for (int i = 0; i < 8; i++) begin
            io_write(PORT, seq_at(i), i == 2);
            io_write(16'h007E, 8'h58, 1'b0);
            io_write(16'h017F, 8'h58, 1'b0);
            io_read((i == 7) ? 8'h86 : 8'h06, "t5_read");
        end
        io_write(PORT, 8'h88, 1'b0);
        io_read(8'h0E, "t5_after");

        // Reset lands mid-write: the captured 'E' must not commit afterwards.
        @(posedge clk); #1;
        a = PORT; din = 8'h45; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; model_reset();
        @(posedge clk); #1;
        iorq_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("rst_mid_enable", 32'(enable), 32'h0);
        write_str("NABLEWR");
        chk("rst_mid_armed", 32'(armed), 32'd0);

`ifdef IO_UNLOCK_TIMEOUT_EN
        write_str("ENABLEWR");
        repeat (16) @(posedge clk);
        #3 chk("t6_still_armed", 32'(armed), 32'd1);
        @(posedge clk);
        #3 chk("t6_expired", 32'(armed), 32'd0);
        io_write(PORT, 8'h8F, 1'b0);
        chk("t6_unchanged", 32'(enable), 32'h0);
        write_str("ENABLEWR");
        repeat (4) @(posedge clk);
        io_write(PORT, 8'h8F, 1'b0);
        chk("t6_enable", 32'(enable), 32'hF);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
